panda_risc_v_div_req_gen: RTL and testbench

Request generator that sits directly upstream of the multi-cycle divider. It accepts RV32M DIV/DIVU/REM/REMU requests from the execute-dispatch stage and extends the 32-bit operands to the 33-bit signed form the divider consumes. It registers the request through a 2-entry skid buffer so that the upstream ready is registered, and it limits the number of requests in flight inside the divider with a credit counter. It also supports a pipeline flush that drops requests not yet issued.

---
 rtl/panda_risc_v_pkg.sv | 25 ++
 rtl/panda_risc_v_skid_buf.sv | 82 ++++++++
 rtl/panda_risc_v_div_req_gen.sv | 104 ++++++++++
 tb/tb_panda_risc_v_div_req_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_risc_v_pkg.sv
// Shared definitions for the panda RISC-V divider request path: RV32M division
// encodings and the bit layout of the packed request word held in the skid buffer.
package panda_risc_v_pkg;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  localparam int unsigned REQ_REM_SEL_BIT = 0;
  localparam int unsigned REQ_OP_A_LSB    = 1;
  localparam int unsigned REQ_OP_A_MSB    = 33;
  localparam int unsigned REQ_OP_B_LSB    = 34;
  localparam int unsigned REQ_OP_B_MSB    = 66;
  localparam int unsigned REQ_RD_ID_LSB   = 67;
  localparam int unsigned REQ_RD_ID_MSB   = 71;
  localparam int unsigned REQ_INST_ID_LSB = 72;

  // Widen a 32-bit operand to the 33-bit signed form the divider consumes.
  function automatic logic [32:0] extend_operand(input logic [31:0] op,
                                                 input logic        is_unsigned);
    return is_unsigned ? {1'b0, op} : {op[31], op};
  endfunction

endpackage

// File: rtl/panda_risc_v_skid_buf.sv
// Generic 2-entry pipeline slice with a registered upstream ready: a main output
// register plus one skid register that absorbs the request arriving while stalled.
module panda_risc_v_skid_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              skid_valid_o
);

  // Handshakes: a transfer happens on a side exactly when its valid and ready are
  // both high at a rising clk edge; m_ready_i must already include any issue gating.
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              s_ready_q;
  logic              s_hs;
  logic              consume;

  assign s_hs    = s_valid_i & s_ready_q;
  assign consume = main_valid_q & m_ready_i;

  always_comb begin
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      // s_ready is low whenever skid holds data, so no capture can coincide here.
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (s_hs) begin
        main_data_d = s_data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (s_hs) begin
      if (!main_valid_q) begin
        main_data_d  = s_data_i;
        main_valid_d = 1'b1;
      end else begin
        skid_data_d  = s_data_i;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      s_ready_q    <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      s_ready_q    <= ~skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

  assign s_ready_o    = s_ready_q;
  assign m_data_o     = main_data_q;
  assign m_valid_o    = main_valid_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/panda_risc_v_div_req_gen.sv
// Divider request generator: extends RV32M division operands, buffers requests in a
// registered-ready skid slice and limits divider occupancy with a credit counter.
module panda_risc_v_div_req_gen
  import panda_risc_v_pkg::*;
#(
  parameter int unsigned inst_id_width    = 4,
  parameter int unsigned max_outstanding  = 2,
  parameter int          simulation_delay = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              s_req_op_a,
  input  logic [31:0]              s_req_op_b,
  input  logic [2:0]               s_req_funct3,
  input  logic [4:0]               s_req_rd_id,
  input  logic [inst_id_width-1:0] s_req_inst_id,
  input  logic                     s_req_valid,
  output logic                     s_req_ready,
  output logic [32:0]              m_div_req_op_a,
  output logic [32:0]              m_div_req_op_b,
  output logic                     m_div_req_rem_sel,
  output logic [4:0]               m_div_req_rd_id,
  output logic [inst_id_width-1:0] m_div_req_inst_id,
  output logic                     m_div_req_valid,
  input  logic                     m_div_req_ready,
  input  logic                     div_res_retire,
  input  logic                     flush,
  output logic                     div_busy,
  output logic [2:0]               outstanding_cnt
);

  localparam int unsigned REQ_W = REQ_INST_ID_LSB + inst_id_width;
  localparam logic [2:0]  MAX_CNT = 3'(max_outstanding);

  logic [REQ_W-1:0] req_word_in;
  logic [REQ_W-1:0] req_word_out;
  logic             main_valid;
  logic             skid_valid;
  logic             credit_ok;
  logic             issue;
  logic [2:0]       cnt_q, cnt_d;

  assign req_word_in = {s_req_inst_id,
                        s_req_rd_id,
                        extend_operand(s_req_op_b, s_req_funct3[0]),
                        extend_operand(s_req_op_a, s_req_funct3[0]),
                        s_req_funct3[1]};

  panda_risc_v_skid_buf #(
    .DATA_W (REQ_W)
  ) u_skid_buf (
    .clk          (clk),
    .resetn       (resetn),
    .flush_i      (flush),
    .s_data_i     (req_word_in),
    .s_valid_i    (s_req_valid),
    .s_ready_o    (s_req_ready),
    .m_data_o     (req_word_out),
    .m_valid_o    (main_valid),
    .m_ready_i    (m_div_req_ready & credit_ok),
    .skid_valid_o (skid_valid)
  );

  assign credit_ok       = cnt_q < MAX_CNT;
  assign m_div_req_valid = main_valid & credit_ok;
  assign issue           = m_div_req_valid & m_div_req_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !div_res_retire) begin
      cnt_d = cnt_q + 3'd1;
    end else if (!issue && div_res_retire && cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A retire with no credit outstanding means the divider and this counter disagree.
  if (simulation_delay >= 0) begin : g_sim_checks
    always_ff @(posedge clk) begin
      if (resetn) begin
        assert (!(div_res_retire && cnt_q == 3'd0))
          else $error("div_res_retire pulsed with outstanding_cnt == 0");
      end
    end
  end

  assign m_div_req_rem_sel = req_word_out[REQ_REM_SEL_BIT];
  assign m_div_req_op_a    = req_word_out[REQ_OP_A_MSB:REQ_OP_A_LSB];
  assign m_div_req_op_b    = req_word_out[REQ_OP_B_MSB:REQ_OP_B_LSB];
  assign m_div_req_rd_id   = req_word_out[REQ_RD_ID_MSB:REQ_RD_ID_LSB];
  assign m_div_req_inst_id = req_word_out[REQ_W-1:REQ_INST_ID_LSB];

  assign outstanding_cnt = cnt_q;
  assign div_busy        = main_valid | skid_valid | (cnt_q != 3'd0);

endmodule

// File: tb/tb_panda_risc_v_div_req_gen.sv
// Directed bench for panda_risc_v_div_req_gen: extension, backpressure, credits,
// flush and asynchronous reset, with hand-computed expectations.
module tb_panda_risc_v_div_req_gen;
  import panda_risc_v_pkg::*;

  logic        clk;
  logic        resetn;
  logic [31:0] s_req_op_a;
  logic [31:0] s_req_op_b;
  logic [2:0]  s_req_funct3;
  logic [4:0]  s_req_rd_id;
  logic [3:0]  s_req_inst_id;
  logic        s_req_valid;
  logic        s_req_ready;
  logic [32:0] m_div_req_op_a;
  logic [32:0] m_div_req_op_b;
  logic        m_div_req_rem_sel;
  logic [4:0]  m_div_req_rd_id;
  logic [3:0]  m_div_req_inst_id;
  logic        m_div_req_valid;
  logic        m_div_req_ready;
  logic        div_res_retire;
  logic        flush;
  logic        div_busy;
  logic [2:0]  outstanding_cnt;

  int checks;
  int errors;

  panda_risc_v_div_req_gen #(
    .inst_id_width    (4),
    .max_outstanding  (2),
    .simulation_delay (1)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .s_req_op_a        (s_req_op_a),
    .s_req_op_b        (s_req_op_b),
    .s_req_funct3      (s_req_funct3),
    .s_req_rd_id       (s_req_rd_id),
    .s_req_inst_id     (s_req_inst_id),
    .s_req_valid       (s_req_valid),
    .s_req_ready       (s_req_ready),
    .m_div_req_op_a    (m_div_req_op_a),
    .m_div_req_op_b    (m_div_req_op_b),
    .m_div_req_rem_sel (m_div_req_rem_sel),
    .m_div_req_rd_id   (m_div_req_rd_id),
    .m_div_req_inst_id (m_div_req_inst_id),
    .m_div_req_valid   (m_div_req_valid),
    .m_div_req_ready   (m_div_req_ready),
    .div_res_retire    (div_res_retire),
    .flush             (flush),
    .div_busy          (div_busy),
    .outstanding_cnt   (outstanding_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [3:0] id);
    s_req_op_a    = a;
    s_req_op_b    = b;
    s_req_funct3  = f3;
    s_req_rd_id   = rd;
    s_req_inst_id = id;
    s_req_valid   = 1'b1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    resetn          = 1'b0;
    s_req_op_a      = '0;
    s_req_op_b      = '0;
    s_req_funct3    = FUNCT3_DIV;
    s_req_rd_id     = '0;
    s_req_inst_id   = '0;
    s_req_valid     = 1'b0;
    m_div_req_ready = 1'b1;
    div_res_retire  = 1'b0;
    flush           = 1'b0;
    #12;
    check("rst_s_ready", s_req_ready, 1);
    check("rst_m_valid", m_div_req_valid, 0);
    check("rst_cnt", outstanding_cnt, 0);
    check("rst_busy", div_busy, 0);
    resetn = 1'b1;
    tick();

    // Signed extension (DIV)
    drive_req(32'hFFFF_FFF9, 32'h0000_0002, FUNCT3_DIV, 5'd3, 4'h1);
    tick();
    s_req_valid = 1'b0;
    check("div_valid", m_div_req_valid, 1);
    check("div_op_a", m_div_req_op_a, 64'h1_FFFF_FFF9);
    check("div_op_b", m_div_req_op_b, 64'h0_0000_0002);
    check("div_rem_sel", m_div_req_rem_sel, 0);
    tick();
    check("div_issued_cnt", outstanding_cnt, 1);
    check("div_issued_valid", m_div_req_valid, 0);
    check("div_busy_inflight", div_busy, 1);
    div_res_retire = 1'b1;
    tick();
    div_res_retire = 1'b0;
    check("div_retired_cnt", outstanding_cnt, 0);
    check("div_idle_busy", div_busy, 0);

    // Unsigned extension (REMU)
    drive_req(32'h8000_0000, 32'h0000_0003, FUNCT3_REMU, 5'd17, 4'hA);
    tick();
    s_req_valid = 1'b0;
    check("remu_op_a", m_div_req_op_a, 64'h0_8000_0000);
    check("remu_op_b", m_div_req_op_b, 64'h0_0000_0003);
    check("remu_rem_sel", m_div_req_rem_sel, 1);
    check("remu_rd_id", m_div_req_rd_id, 17);
    check("remu_inst_id", m_div_req_inst_id, 4'hA);
    tick();
    div_res_retire = 1'b1;
    tick();
    div_res_retire = 1'b0;
    check("remu_retired_cnt", outstanding_cnt, 0);

    // Backpressure: three back-to-back requests with the divider stalled
    m_div_req_ready = 1'b0;
    drive_req(32'h0000_0064, 32'h0000_0007, FUNCT3_DIVU, 5'd1, 4'h1);
    tick();
    check("bp_ready_after_1", s_req_ready, 1);
    drive_req(32'hFFFF_FF00, 32'h0000_0010, FUNCT3_DIV, 5'd2, 4'h2);
    tick();
    check("bp_ready_after_2", s_req_ready, 0);
    check("bp_valid_stall", m_div_req_valid, 1);
    check("bp_head_r1", m_div_req_op_a, 64'h0_0000_0064);
    drive_req(32'h0000_1234, 32'h0000_0005, FUNCT3_REM, 5'd3, 4'h3);
    tick();
    check("bp_ready_hold", s_req_ready, 0);
    check("bp_stable_a", m_div_req_op_a, 64'h0_0000_0064);
    check("bp_stable_id", m_div_req_inst_id, 4'h1);
    tick();
    check("bp_stable_a2", m_div_req_op_a, 64'h0_0000_0064);
    m_div_req_ready = 1'b1;
    tick();
    check("bp_head_r2", m_div_req_op_a, 64'h1_FFFF_FF00);
    check("bp_cnt_1", outstanding_cnt, 1);
    check("bp_ready_back", s_req_ready, 1);
    div_res_retire = 1'b1;
    tick();
    s_req_valid    = 1'b0;
    div_res_retire = 1'b0;
    check("bp_issue_retire_cnt", outstanding_cnt, 1);
    check("bp_head_r3", m_div_req_op_a, 64'h0_0000_1234);
    check("bp_r3_rem_sel", m_div_req_rem_sel, 1);
    check("bp_r3_valid", m_div_req_valid, 1);
    tick();
    check("bp_cnt_2", outstanding_cnt, 2);
    check("bp_drained", m_div_req_valid, 0);
    div_res_retire = 1'b1;
    tick();
    tick();
    div_res_retire = 1'b0;
    check("bp_cnt_0", outstanding_cnt, 0);

    // Credit limit: A, B issue; C waits for a retire
    drive_req(32'h0000_000A, 32'h1, FUNCT3_DIV, 5'd4, 4'h4);
    tick();
    drive_req(32'h0000_000B, 32'h1, FUNCT3_DIV, 5'd5, 4'h5);
    tick();
    drive_req(32'h0000_000C, 32'h1, FUNCT3_DIV, 5'd6, 4'h6);
    tick();
    s_req_valid = 1'b0;
    check("cr_cnt_2", outstanding_cnt, 2);
    check("cr_valid_gated", m_div_req_valid, 0);
    check("cr_head_c", m_div_req_op_a, 64'h0_0000_000C);
    check("cr_busy", div_busy, 1);
    tick();
    check("cr_still_gated", m_div_req_valid, 0);
    div_res_retire = 1'b1;
    #1;
    check("cr_no_issue_at_2", m_div_req_valid, 0);
    tick();
    div_res_retire = 1'b0;
    check("cr_cnt_after_retire", outstanding_cnt, 1);
    check("cr_c_valid", m_div_req_valid, 1);
    tick();
    check("cr_c_issued_cnt", outstanding_cnt, 2);
    check("cr_c_gone", m_div_req_valid, 0);
    div_res_retire = 1'b1;
    tick();
    tick();
    div_res_retire = 1'b0;
    check("cr_cnt_0", outstanding_cnt, 0);

    // Flush: one in flight, two buffered
    m_div_req_ready = 1'b0;
    drive_req(32'h0000_0111, 32'h1, FUNCT3_DIVU, 5'd7, 4'h7);
    tick();
    s_req_valid     = 1'b0;
    m_div_req_ready = 1'b1;
    tick();
    m_div_req_ready = 1'b0;
    check("fl_inflight_cnt", outstanding_cnt, 1);
    drive_req(32'h0000_0222, 32'h1, FUNCT3_DIVU, 5'd8, 4'h8);
    tick();
    drive_req(32'h0000_0333, 32'h1, FUNCT3_DIVU, 5'd9, 4'h9);
    tick();
    s_req_valid = 1'b0;
    check("fl_full_ready", s_req_ready, 0);
    check("fl_head_y", m_div_req_op_a, 64'h0_0000_0222);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid_cleared", m_div_req_valid, 0);
    check("fl_ready_back", s_req_ready, 1);
    check("fl_cnt_kept", outstanding_cnt, 1);
    check("fl_busy_inflight", div_busy, 1);
    drive_req(32'h0000_0444, 32'h1, FUNCT3_DIVU, 5'd10, 4'hB);
    flush = 1'b1;
    tick();
    flush       = 1'b0;
    s_req_valid = 1'b0;
    check("fl_hs_dropped", m_div_req_valid, 0);
    tick();
    check("fl_hs_dropped_later", m_div_req_valid, 0);
    div_res_retire = 1'b1;
    tick();
    div_res_retire = 1'b0;
    check("fl_cnt_0", outstanding_cnt, 0);
    check("fl_busy_0", div_busy, 0);

    // Asynchronous reset mid-operation
    m_div_req_ready = 1'b1;
    drive_req(32'h0000_0555, 32'h1, FUNCT3_DIV, 5'd11, 4'hC);
    tick();
    tick();
    m_div_req_ready = 1'b0;
    drive_req(32'h0000_0666, 32'h1, FUNCT3_DIV, 5'd12, 4'hD);
    tick();
    s_req_valid = 1'b0;
    check("ar_pre_cnt", outstanding_cnt, 1);
    check("ar_pre_valid", m_div_req_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_valid", m_div_req_valid, 0);
    check("ar_cnt", outstanding_cnt, 0);
    check("ar_busy", div_busy, 0);
    check("ar_ready", s_req_ready, 1);
    #3;
    resetn = 1'b1;
    tick();
    check("ar_post_valid", m_div_req_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
